// File: rtl/wide_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared types and constants for the wide_add_sequencer slice.
//   wa_state_t    : sequencer FSM state (IDLE / RUN / DONE)
//   WA_DEF_WIDTH  : default adder slice width in bits
//   WA_DEF_BEATS  : default number of slices per operand
//   wa_beat_w()   : width of the beat counter for a given slice count
// -----------------------------------------------------------------------------
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wa_state_t;

    localparam int WA_DEF_WIDTH = 16;
    localparam int WA_DEF_BEATS = 4;

    // A counter needs at least one bit even when $clog2 would return 0.
    function automatic int wa_beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// -----------------------------------------------------------------------------
// rippleCarryAdder
// Purely combinational ripple-carry adder of `width` bits.
//   A, B : addends
//   c_i  : carry into bit 0
//   S    : sum bits
//   c_o  : carry out of the top bit
// -----------------------------------------------------------------------------
module rippleCarryAdder #(
    parameter int width = 16
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             c_i,
    output logic [width-1:0] S,
    output logic             c_o
);

    // w_carry[i] is the carry into bit i; w_carry[width] leaves the slice.
    logic [width:0] w_carry;

    assign w_carry[0] = c_i;

    for (genvar i = 0; i < width; i++) begin : g_bit
        assign S[i]         = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign c_o = w_carry[width];

endmodule

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Adds two WIDTH*BEATS-bit operands with a single WIDTH-bit ripple adder,
// one slice per cycle, least-significant slice first, carry kept in a register.
// Optional macro: WIDE_ADD_OVF_EN adds the signed-overflow output ovf_o.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B, c_i)
//   out_valid/out_ready : result handshake (S, c_o, ovf_o)
// Latency is BEATS+1 cycles; one operation in flight at a time.
// -----------------------------------------------------------------------------
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = WA_DEF_WIDTH,
    parameter int BEATS = WA_DEF_BEATS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*BEATS-1:0] A,
    input  logic [WIDTH*BEATS-1:0] B,
    input  logic                   c_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*BEATS-1:0] S,
    output logic                   c_o
`ifdef WIDE_ADD_OVF_EN
    ,
    output logic                   ovf_o
`endif
);

    localparam int              OPW       = WIDTH * BEATS;
    localparam int              BW        = wa_beat_w(BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);

    wa_state_t        r_state;
    wa_state_t        w_next_state;
    logic [OPW-1:0]   r_a;
    logic [OPW-1:0]   r_b;
    logic [OPW-1:0]   r_sum;
    logic             r_carry;
    logic [BW-1:0]    r_beat;
    logic             r_c_o;
    logic             r_in_ready;
    logic             r_out_valid;
`ifdef WIDE_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_slice_a;
    logic [WIDTH-1:0] w_slice_b;
    logic [WIDTH-1:0] w_slice_s;
    logic             w_slice_co;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (r_beat == LAST_BEAT) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Per-state control strobes; acceptance also needs the registered ready,
    // which stays low for the first cycle after reset.
    always_comb begin
        w_accept = 1'b0;
        w_run    = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = in_valid & r_in_ready;
            end
            RUN: begin
                w_run  = 1'b1;
                w_last = (r_beat == LAST_BEAT);
            end
            DONE: begin
                w_run = 1'b0;
            end
            default: begin
                w_run = 1'b0;
            end
        endcase
    end

    assign w_slice_a = r_a[r_beat*WIDTH +: WIDTH];
    assign w_slice_b = r_b[r_beat*WIDTH +: WIDTH];

    rippleCarryAdder #(
        .width (WIDTH)
    ) u_slice_add (
        .A   (w_slice_a),
        .B   (w_slice_b),
        .c_i (r_carry),
        .S   (w_slice_s),
        .c_o (w_slice_co)
    );

    // Operand capture, per-beat accumulation and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_beat      <= '0;
            r_c_o       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == DONE);
            if (w_accept) begin
                r_a     <= A;
                r_b     <= B;
                r_carry <= c_i;
                r_beat  <= '0;
            end else if (w_run) begin
                r_sum[r_beat*WIDTH +: WIDTH] <= w_slice_s;
                r_carry                      <= w_slice_co;
                if (w_last) begin
                    // Counter parks on the last beat instead of wrapping.
                    r_c_o <= w_slice_co;
`ifdef WIDE_ADD_OVF_EN
                    r_ovf <= (r_a[OPW-1] == r_b[OPW-1]) &&
                             (w_slice_s[WIDTH-1] != r_a[OPW-1]);
`endif
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign S         = r_sum;
    assign c_o       = r_c_o;
`ifdef WIDE_ADD_OVF_EN
    assign ovf_o     = r_ovf;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_add_sequencer
// Self-checking bench for wide_add_sequencer (WIDTH=16, BEATS=4).
// Expected results come from whole-operand arithmetic on 65/66-bit values.
// -----------------------------------------------------------------------------
module tb_wide_add_sequencer;

    localparam int WIDTH = 16;
    localparam int BEATS = 4;
    localparam int OPW   = WIDTH * BEATS;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] A;
    logic [OPW-1:0] B;
    logic           c_i;
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] S;
    logic           c_o;
`ifdef WIDE_ADD_OVF_EN
    logic           ovf_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(
        .WIDTH (WIDTH),
        .BEATS (BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c_i       (c_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c_o       (c_o)
`ifdef WIDE_ADD_OVF_EN
        ,
        .ovf_o     (ovf_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width sum including the carry-out bit.
    function automatic logic [OPW:0] ref_sum(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                             input logic ci);
        return {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, ci};
    endfunction

    // Reference: signed result falls outside the representable range.
    function automatic logic ref_ovf(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                     input logic ci);
        logic signed [OPW+1:0] t;
        logic signed [OPW+1:0] max_pos;
        logic signed [OPW+1:0] min_neg;
        t       = $signed({{2{a[OPW-1]}}, a}) + $signed({{2{b[OPW-1]}}, b}) +
                  $signed({{(OPW+1){1'b0}}, ci});
        max_pos = $signed({3'b000, {(OPW-1){1'b1}}});
        min_neg = $signed({3'b111, {(OPW-1){1'b0}}});
        return (t > max_pos) || (t < min_neg);
    endfunction

    function automatic logic dut_ovf();
`ifdef WIDE_ADD_OVF_EN
        return ovf_o;
`else
        return 1'b0;
`endif
    endfunction

    // Issues one operation and waits for out_valid; lat counts edges from the
    // acceptance edge (inclusive) to the first cycle out_valid is seen, -1 on timeout.
    task automatic do_op(input logic [OPW-1:0] op_a, input logic [OPW-1:0] op_b,
                         input logic op_ci, input bit scramble,
                         output logic [OPW-1:0] s, output logic co, output logic ov,
                         output int lat);
        int guard;
        guard = 0;
        lat   = -1;
        s     = '0;
        co    = 1'b0;
        ov    = 1'b0;
        while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (in_ready !== 1'b1) return;
        A        = op_a;
        B        = op_b;
        c_i      = op_ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (scramble) begin
                A   = {$urandom, $urandom};
                B   = {$urandom, $urandom};
                c_i = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
        end
        if (out_valid !== 1'b1) begin
            lat = -1;
            return;
        end
        s  = S;
        co = c_o;
        ov = dut_ovf();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        c_i       = 1'b0;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (S !== '0) begin failures++; $display("FAIL reset_S: got %h expected 0", S); end
        checks++; if (c_o !== 1'b0) begin failures++; $display("FAIL reset_c_o: got %b expected 0", c_o); end
        checks++; if (dut_ovf() !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", dut_ovf()); end
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_basic();
        logic [OPW-1:0] s;
        logic co, ov;
        int lat;
        do_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1, 1'b0, s, co, ov, lat);
        checks++; if (lat !== BEATS + 1) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat, BEATS + 1); end
        checks++; if (s !== 64'h0000_0000_0000_0003) begin failures++; $display("FAIL basic_S: got %h expected 3", s); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL basic_c_o: got %b expected 0", co); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_in_done: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_carry_ripple();
        logic [OPW-1:0] s;
        logic co, ov;
        int lat;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, s, co, ov, lat);
        checks++; if (s !== 64'h0) begin failures++; $display("FAIL ripple_S: got %h expected 0", s); end
        checks++; if (co !== 1'b1) begin failures++; $display("FAIL ripple_c_o: got %b expected 1", co); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [OPW-1:0] s, a, b;
        logic [OPW:0] exp_v;
        logic co, ov, ci;
        int lat;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        ci    = 1'($urandom_range(0, 1));
        exp_v = ref_sum(a, b, ci);
        do_op(a, b, ci, 1'b0, s, co, ov, lat);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (S !== exp_v[OPW-1:0]) begin failures++; $display("FAIL bp_S[%0d]: got %h expected %h", i, S, exp_v[OPW-1:0]); end
            checks++; if (c_o !== exp_v[OPW]) begin failures++; $display("FAIL bp_c_o[%0d]: got %b expected %b", i, c_o, exp_v[OPW]); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_input_isolation();
        logic [OPW-1:0] s, a, b;
        logic [OPW:0] exp_v;
        logic co, ov, ci;
        int lat;
        for (int k = 0; k < 4; k++) begin
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
            ci    = 1'($urandom_range(0, 1));
            exp_v = ref_sum(a, b, ci);
            do_op(a, b, ci, 1'b1, s, co, ov, lat);
            checks++; if (s !== exp_v[OPW-1:0]) begin failures++; $display("FAIL iso_S[%0d]: got %h expected %h", k, s, exp_v[OPW-1:0]); end
            checks++; if (co !== exp_v[OPW]) begin failures++; $display("FAIL iso_c_o[%0d]: got %b expected %b", k, co, exp_v[OPW]); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        int spurious;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmo_start_ready: got %b expected 1", in_ready); end
        A        = {$urandom, $urandom};
        B        = {$urandom, $urandom};
        c_i      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmo_valid: got %b expected 0", out_valid); end
        checks++; if (S !== '0) begin failures++; $display("FAIL rmo_S: got %h expected 0", S); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rmo_ready_in_reset: got %b expected 0", in_ready); end
        checks++; if (c_o !== 1'b0) begin failures++; $display("FAIL rmo_c_o: got %b expected 0", c_o); end
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmo_ready_after: got %b expected 1", in_ready); end
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL rmo_spurious: got %0d valid cycles expected 0", spurious); end
    endtask

    task automatic test_random();
        logic [OPW-1:0] s, a, b;
        logic [OPW:0] exp_v;
        logic co, ov, ci;
        int lat;
        for (int k = 0; k < 24; k++) begin
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
            ci    = 1'($urandom_range(0, 1));
            exp_v = ref_sum(a, b, ci);
            out_ready = 1'($urandom_range(0, 1));
            do_op(a, b, ci, 1'b0, s, co, ov, lat);
            checks++; if (lat !== BEATS + 1) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", k, lat, BEATS + 1); end
            checks++; if (s !== exp_v[OPW-1:0]) begin failures++; $display("FAIL rnd_S[%0d]: got %h expected %h", k, s, exp_v[OPW-1:0]); end
            checks++; if (co !== exp_v[OPW]) begin failures++; $display("FAIL rnd_c_o[%0d]: got %b expected %b", k, co, exp_v[OPW]); end
`ifdef WIDE_ADD_OVF_EN
            checks++; if (ov !== ref_ovf(a, b, ci)) begin failures++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", k, ov, ref_ovf(a, b, ci)); end
`endif
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready_after[%0d]: got %b expected 1", k, in_ready); end
        end
    endtask

`ifdef WIDE_ADD_OVF_EN
    task automatic test_overflow();
        logic [OPW-1:0] s;
        logic co, ov;
        int lat;
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, co, ov, lat);
        checks++; if (s !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_S: got %h expected 8000000000000000", s); end
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", ov); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL ovf_c_o: got %b expected 0", co); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_back_pressure();
        test_input_isolation();
        test_reset_mid_op();
        test_random();
`ifdef WIDE_ADD_OVF_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle controller that reuses one `rippleCarryAdder` slice of `WIDTH` bits to add two `WIDTH*BEATS`-bit operands, one slice per cycle, least-significant slice first. The carry is chained through a register. The block sits between an operand producer and a result consumer, each with a valid/ready handshake. It trades latency for area in wide arithmetic paths.

## Interface
Parameters:
- `WIDTH`, 16: bits per adder slice; passed to the adder's `width` parameter.
- `BEATS`, 4: number of slices; operand width is `WIDTH*BEATS`; must be ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: operands and carry-in are valid.
- `in_ready`, out, 1: block can accept operands.
- `A`, in, `WIDTH*BEATS`: operand A.
- `B`, in, `WIDTH*BEATS`: operand B.
- `c_i`, in, 1: carry-in to slice 0.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: consumer accepts the result.
- `S`, out, `WIDTH*BEATS`: sum, modulo 2^(`WIDTH*BEATS`).
- `c_o`, out, 1: carry-out of the top slice.
- `ovf_o`, out, 1: signed overflow; present only with `WIDE_ADD_OVF_EN`.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`. Reset state is `IDLE`.
- **`IDLE`**
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `A`, `B` and `c_i` into internal registers, set beat counter to 0, go to `RUN`.
- **`RUN`**
  - Each cycle, the adder gets slice `beat` of A and B, plus the carry register.
  - Slice `beat` of the result register takes the adder's `S`; the carry register takes the adder's `c_o`; `beat` increments.
  - When `beat == BEATS-1`, the final carry goes to `c_o` and the FSM goes to `DONE`.
- **`DONE`**
  - `out_valid`=1.
  - `S`, `c_o` and `ovf_o` are held stable until `out_valid & out_ready`, then go to `IDLE`.
- `in_ready` is 0 in `RUN` and `DONE`; operand inputs are ignored there.
- Captured operands are used; input changes after acceptance have no effect.
- `out_ready` may be high before `out_valid`. Completion then occurs on the first `DONE` cycle.
- No pipelining: one operation in flight at a time.
- Beat counter width is `$clog2(BEATS)`; it never wraps past `BEATS-1`.
- Arithmetic wraps modulo 2^(`WIDTH*BEATS`); the carry beyond the top slice is reported only on `c_o`.

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 in `IDLE`; `out_valid`=0; `S`=0; `c_o`=0; `ovf_o`=0; internal registers=0.
- Acceptance at edge n puts the FSM in `RUN` for edges n+1 … n+`BEATS`.
- `out_valid` is high from cycle n+`BEATS`+1; latency is `BEATS`+1 cycles.
- Result consumed at edge m: `in_ready`=1 from cycle m+1. Minimum issue interval is `BEATS`+2 cycles.
- `rst` asserted in any state aborts the operation at the next edge. All outputs take reset values and no `out_valid` pulse is produced.

## Configuration
- `WIDE_ADD_OVF_EN` defined:
  - `ovf_o` exists.
  - It is registered at the last beat as `(A[msb]==B[msb]) && (S[msb]!=A[msb])`, using the captured operands.
  - It is held with `S` in `DONE`.
- `WIDE_ADD_OVF_EN` undefined: the port and its logic are absent.

## Structure
- Package `wide_add_pkg`:
  - state enum `wa_state_t` (`IDLE`, `RUN`, `DONE`);
  - localparam for the default `WIDTH`/`BEATS`;
  - a function returning the beat-counter width.
- Sub-module: one `rippleCarryAdder` instance, named `u_slice_add`, with `.width(WIDTH)`. It is purely combinational. Slice selection uses indexed part-selects `[beat*WIDTH +: WIDTH]`.

## Test plan
All scenarios use `WIDTH`=16 and `BEATS`=4.
- **Basic add:** A=0x0000_0000_0000_0001, B=0x0000_0000_0000_0001, c_i=1 → S=0x0000_0000_0000_0003, c_o=0; `out_valid` exactly 5 cycles after acceptance.
- **Full carry ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=0, c_i=1 → S=0, c_o=1; verifies the carry across all four beats.
- **Back-pressure:** `out_ready` held 0 for 10 cycles → S, c_o and `out_valid` stable, `in_ready`=0; `out_ready`=1 → `in_ready`=1 next cycle.
- **Input isolation:** change A and B to random values during `RUN` → result matches the captured operands.
- **Reset mid-op:** assert `rst` on beat 2 → next cycle `out_valid`=0, S=0, `in_ready`=1 one cycle after `rst` drops; no spurious result.
- **Overflow (`WIDE_ADD_OVF_EN`):** A=0x7FFF_FFFF_FFFF_FFFF, B=1, c_i=0 → S=0x8000_0000_0000_0000, `ovf_o`=1, c_o=0.
